// File: rtl/maze_session_ctrl_if.sv
// Front-end / display bundle for the maze session controller.
// master drives the session inputs, slave is the controller.
interface maze_session_ctrl_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int COORD_W     = 4,
  parameter int SEC_W       = 10,
  parameter int LEVEL_W     = 4
) ();
  logic                           start_btn;
  logic                           carve_done;
  logic [COORD_W-1:0]             finish_x;
  logic [COORD_W-1:0]             finish_y;
  logic [NUM_PLAYERS*COORD_W-1:0] player_x;
  logic [NUM_PLAYERS*COORD_W-1:0] player_y;
  logic                           carve_start;
  logic                           move_en;
  logic [2:0]                     state;
  logic [NUM_PLAYERS-1:0]         winner;
  logic [SEC_W-1:0]               elapsed;
  logic [LEVEL_W-1:0]             level;
  logic                           timeout;

  modport master (
    output start_btn,
    output carve_done,
    output finish_x,
    output finish_y,
    output player_x,
    output player_y,
    input  carve_start,
    input  move_en,
    input  state,
    input  winner,
    input  elapsed,
    input  level,
    input  timeout
  );

  modport slave (
    input  start_btn,
    input  carve_done,
    input  finish_x,
    input  finish_y,
    input  player_x,
    input  player_y,
    output carve_start,
    output move_en,
    output state,
    output winner,
    output elapsed,
    output level,
    output timeout
  );
endinterface

// File: rtl/maze_session_ctrl.sv
// Maze game session sequencer: carve, play, win and timeout
// for up to NUM_PLAYERS characters, with level and seconds tracking.
module maze_session_ctrl #(
  parameter int          NUM_PLAYERS = 2,
  parameter int          COORD_W     = 4,
  parameter int          SEC_W       = 10,
  parameter int          CLK_PER_SEC = 50_000_000,
  parameter int unsigned TIME_LIMIT  = 300,
  parameter int          LEVEL_W     = 4
) (
  input logic                clk,
  input logic                reset,
  maze_session_ctrl_if.slave bus
);

  localparam int PRE_W = (CLK_PER_SEC > 2) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_SEC - 1);
  localparam logic [31:0] LIMIT = 32'(TIME_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CARVE   = 3'd1,
    S_PLAY    = 3'd2,
    S_WIN     = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic                   btn_q;
  logic                   low_seen;
  logic                   edge_q;
  logic                   carve_start_q;
  logic                   move_en_q;
  logic                   timeout_q;
  logic [NUM_PLAYERS-1:0] winner_q;
  logic [NUM_PLAYERS-1:0] hit_vec;
  logic [SEC_W-1:0]       elapsed_q;
  logic [LEVEL_W-1:0]     level_q;
  logic [PRE_W-1:0]       pre_q;
  logic                   any_hit;
  logic                   time_hit;
  logic                   sec_tick;
  logic                   carve_entry;
  logic                   play_to_win;
  logic                   play_to_out;

  // Compare every player position against the finish tile
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      hit_vec[i] =
        (bus.player_x[i*COORD_W +: COORD_W] == bus.finish_x) &&
        (bus.player_y[i*COORD_W +: COORD_W] == bus.finish_y);
    end
  end

  assign any_hit  = |hit_vec;
  assign time_hit = (TIME_LIMIT != 0) &&
                    (32'(elapsed_q) == LIMIT);
  assign sec_tick = (pre_q == PRE_LAST);

  // Start-button edge detector; a level already high when
  // reset ends must fall before it can count as a press.
  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_q    <= 1'b0;
      low_seen <= ~bus.start_btn;
      edge_q   <= 1'b0;
    end else begin
      btn_q    <= bus.start_btn;
      low_seen <= low_seen | ~bus.start_btn;
      edge_q   <= bus.start_btn & ~btn_q & low_seen;
    end
  end

  // Next-state decode; finish beats timeout beats abort
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (edge_q) state_d = S_CARVE;
      end
      S_CARVE: begin
        if (!carve_start_q && bus.carve_done)
          state_d = S_PLAY;
      end
      S_PLAY: begin
        if (any_hit)       state_d = S_WIN;
        else if (time_hit) state_d = S_TIMEOUT;
        else if (edge_q)   state_d = S_CARVE;
      end
      S_WIN: begin
        if (edge_q) state_d = S_CARVE;
      end
      S_TIMEOUT: begin
        if (edge_q) state_d = S_CARVE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign carve_entry = (state_d == S_CARVE) &&
                       (state_q != S_CARVE);
  assign play_to_win = (state_q == S_PLAY) &&
                       (state_d == S_WIN);
  assign play_to_out = (state_q == S_PLAY) &&
                       (state_d == S_TIMEOUT);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Registered control outputs derived from the next state
  always_ff @(posedge clk) begin
    if (!reset) begin
      carve_start_q <= 1'b0;
      move_en_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      carve_start_q <= carve_entry;
      move_en_q     <= (state_d == S_PLAY);
      timeout_q     <= (state_d == S_TIMEOUT);
    end
  end

  // Seconds prescaler and saturating elapsed counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      pre_q     <= '0;
      elapsed_q <= '0;
    end else if (carve_entry) begin
      pre_q     <= '0;
      elapsed_q <= '0;
    end else if (state_q == S_PLAY) begin
      if (sec_tick) begin
        pre_q <= '0;
        if (elapsed_q != '1)
          elapsed_q <= elapsed_q + 1'b1;
      end else begin
        pre_q <= pre_q + 1'b1;
      end
    end
  end

  // Winner latch and level counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      winner_q <= '0;
      level_q  <= '0;
    end else if (carve_entry) begin
      winner_q <= '0;
    end else if (play_to_win) begin
      winner_q <= hit_vec;
      level_q  <= level_q + 1'b1;
    end else if (play_to_out) begin
      level_q  <= '0;
    end
  end

  assign bus.carve_start = carve_start_q;
  assign bus.move_en     = move_en_q;
  assign bus.state       = state_q;
  assign bus.winner      = winner_q;
  assign bus.elapsed     = elapsed_q;
  assign bus.level       = level_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_maze_session_ctrl.sv
// Scoreboard bench for maze_session_ctrl: one instance for the
// level/tie/timeout/abort/wrap flows, one for elapsed saturation.
module tb_maze_session_ctrl;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CARV = 3'd1;
  localparam logic [2:0] PLAY = 3'd2;
  localparam logic [2:0] WIN  = 3'd3;
  localparam logic [2:0] TOUT = 3'd4;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   t0 = 0;
  int   checks = 0;
  int   errors = 0;
  int   lv_model;

  typedef struct {
    int         cyc;
    bit         inst;
    logic [2:0] st;
    logic       cs;
    logic       me;
    logic       to;
    logic [1:0] w;
    int         el;
    int         lv;
    string      name;
  } exp_t;

  exp_t sb[$];

  maze_session_ctrl_if #(
    .NUM_PLAYERS(2), .COORD_W(4), .SEC_W(10), .LEVEL_W(4)
  ) bus_a ();

  maze_session_ctrl_if #(
    .NUM_PLAYERS(2), .COORD_W(4), .SEC_W(2), .LEVEL_W(4)
  ) bus_b ();

  maze_session_ctrl #(
    .NUM_PLAYERS(2), .COORD_W(4), .SEC_W(10),
    .CLK_PER_SEC(4), .TIME_LIMIT(3), .LEVEL_W(4)
  ) dut_a (
    .clk(clk),
    .reset(reset),
    .bus(bus_a)
  );

  maze_session_ctrl #(
    .NUM_PLAYERS(2), .COORD_W(4), .SEC_W(2),
    .CLK_PER_SEC(2), .TIME_LIMIT(0), .LEVEL_W(4)
  ) dut_b (
    .clk(clk),
    .reset(reset),
    .bus(bus_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit inst, input int k,
                     input logic [2:0] st, input logic cs,
                     input logic me, input logic to,
                     input logic [1:0] w, input int el,
                     input int lv, input string name);
    exp_t e;
    e.cyc = t0 + k;
    e.inst = inst;
    e.st = st;
    e.cs = cs;
    e.me = me;
    e.to = to;
    e.w = w;
    e.el = el;
    e.lv = lv;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic go(input int k);
    while (cyc < t0 + k) @(negedge clk);
  endtask

  task automatic place_a(input int x0, input int y0,
                         input int x1, input int y1);
    bus_a.player_x = {4'(x1), 4'(x0)};
    bus_a.player_y = {4'(y1), 4'(y0)};
  endtask

  task automatic restart_a();
    bus_a.start_btn = 1'b0;
    @(negedge clk);
    bus_a.start_btn = 1'b1;
    t0 = cyc;
  endtask

  task automatic compare(input exp_t e);
    logic [2:0] st;
    logic       cs, me, to;
    logic [1:0] w;
    int         el, lv;
    if (e.inst) begin
      st = bus_b.state; cs = bus_b.carve_start;
      me = bus_b.move_en; to = bus_b.timeout;
      w = bus_b.winner; el = int'(bus_b.elapsed);
      lv = int'(bus_b.level);
    end else begin
      st = bus_a.state; cs = bus_a.carve_start;
      me = bus_a.move_en; to = bus_a.timeout;
      w = bus_a.winner; el = int'(bus_a.elapsed);
      lv = int'(bus_a.level);
    end
    checks++;
    if (st !== e.st || cs !== e.cs || me !== e.me ||
        to !== e.to || w !== e.w || el != e.el ||
        lv != e.lv) begin
      errors++;
      $display("FAIL %s cyc%0d: got st=%0d cs=%b me=%b to=%b w=%b el=%0d lv=%0d want st=%0d cs=%b me=%b to=%b w=%b el=%0d lv=%0d",
               e.name, cyc, st, cs, me, to, w, el, lv,
               e.st, e.cs, e.me, e.to, e.w, e.el, e.lv);
    end
  endtask

  // Monitor: pops every expectation due in this cycle
  always @(negedge clk) begin : monitor
    int idx;
    idx = 0;
    while (idx < sb.size()) begin
      if (sb[idx].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cyc%0d not sampled (now %0d)",
                 sb[idx].name, sb[idx].cyc, cyc);
        sb.delete(idx);
      end else if (sb[idx].cyc == cyc) begin
        compare(sb[idx]);
        sb.delete(idx);
      end else begin
        idx++;
      end
    end
  end

  initial begin
    reset = 1'b0;
    bus_a.start_btn = 1'b1;
    bus_a.carve_done = 1'b1;
    bus_a.finish_x = 4'd15;
    bus_a.finish_y = 4'd15;
    place_a(0, 0, 1, 0);
    bus_b.start_btn = 1'b0;
    bus_b.carve_done = 1'b1;
    bus_b.finish_x = 4'd15;
    bus_b.finish_y = 4'd15;
    bus_b.player_x = {4'd1, 4'd0};
    bus_b.player_y = 8'd0;

    // Reset held with button high, then release: no edge
    @(negedge clk);
    t0 = cyc;
    chk(0, 1, IDLE, 0, 0, 0, 2'b00, 0, 0, "rst_1");
    chk(0, 2, IDLE, 0, 0, 0, 2'b00, 0, 0, "rst_2");
    chk(0, 3, IDLE, 0, 0, 0, 2'b00, 0, 0, "held_btn_1");
    chk(0, 6, IDLE, 0, 0, 0, 2'b00, 0, 0, "held_btn_2");
    go(2);
    reset = 1'b1;
    go(6);

    // Full level: player 1 reaches the finish
    restart_a();
    chk(0, 1, IDLE, 0, 0, 0, 2'b00, 0, 0, "edge_lat");
    chk(0, 2, CARV, 1, 0, 0, 2'b00, 0, 0, "carve_pulse");
    chk(0, 3, CARV, 0, 0, 0, 2'b00, 0, 0, "carve_hold");
    chk(0, 4, PLAY, 0, 1, 0, 2'b00, 0, 0, "play_entry");
    chk(0, 8, PLAY, 0, 1, 0, 2'b00, 1, 0, "first_sec");
    go(10);
    place_a(0, 0, 15, 15);
    chk(0, 11, WIN, 0, 0, 0, 2'b10, 1, 1, "win_p1");
    chk(0, 14, WIN, 0, 0, 0, 2'b10, 1, 1, "win_hold");
    go(14);

    // Tie: both players land together
    place_a(0, 0, 1, 0);
    restart_a();
    chk(0, 2, CARV, 1, 0, 0, 2'b00, 0, 1, "tie_carve");
    chk(0, 4, PLAY, 0, 1, 0, 2'b00, 0, 1, "tie_play");
    go(5);
    place_a(15, 15, 15, 15);
    chk(0, 6, WIN, 0, 0, 0, 2'b11, 0, 2, "tie_win");
    chk(0, 8, WIN, 0, 0, 0, 2'b11, 0, 2, "tie_hold");
    go(8);

    // Timeout: nobody moves for three seconds
    place_a(0, 0, 1, 0);
    restart_a();
    chk(0, 8, PLAY, 0, 1, 0, 2'b00, 1, 2, "to_el1");
    chk(0, 12, PLAY, 0, 1, 0, 2'b00, 2, 2, "to_el2");
    chk(0, 16, PLAY, 0, 1, 0, 2'b00, 3, 2, "to_el3");
    chk(0, 17, TOUT, 0, 0, 1, 2'b00, 3, 0, "timeout");
    chk(0, 19, TOUT, 0, 0, 1, 2'b00, 3, 0, "to_hold");
    go(19);
    restart_a();
    chk(0, 2, CARV, 1, 0, 0, 2'b00, 0, 0, "to_restart");
    chk(0, 4, PLAY, 0, 1, 0, 2'b00, 0, 0, "to_replay");

    // Finish hit coinciding with a start edge
    go(3);
    bus_a.start_btn = 1'b0;
    go(4);
    bus_a.start_btn = 1'b1;
    chk(0, 5, PLAY, 0, 1, 0, 2'b00, 0, 0, "prio_pre");
    go(5);
    place_a(15, 15, 1, 0);
    chk(0, 6, WIN, 0, 0, 0, 2'b01, 0, 1, "prio_win");
    chk(0, 9, WIN, 0, 0, 0, 2'b01, 0, 1, "prio_hold");
    go(9);

    // Abort in play restarts carving, level kept
    place_a(0, 0, 1, 0);
    restart_a();
    chk(0, 4, PLAY, 0, 1, 0, 2'b00, 0, 1, "ab_play");
    chk(0, 8, PLAY, 0, 1, 0, 2'b00, 1, 1, "ab_el1");
    go(8);
    bus_a.start_btn = 1'b0;
    go(9);
    bus_a.start_btn = 1'b1;
    chk(0, 11, CARV, 1, 0, 0, 2'b00, 0, 1, "abort_carve");
    chk(0, 13, PLAY, 0, 1, 0, 2'b00, 0, 1, "abort_play");
    go(13);
    place_a(15, 15, 1, 0);
    chk(0, 14, WIN, 0, 0, 0, 2'b01, 0, 2, "abort_win");
    go(14);

    // Level wrap: fourteen more wins bring 2 back to 0
    lv_model = 2;
    for (int i = 0; i < 14; i++) begin
      place_a(0, 0, 1, 0);
      restart_a();
      go(4);
      place_a(0, 0, 15, 15);
      lv_model = (lv_model + 1) % 16;
      chk(0, 5, WIN, 0, 0, 0, 2'b10, 0, lv_model, "wrap");
      go(5);
    end
    chk(0, 7, WIN, 0, 0, 0, 2'b10, 0, 0, "wrap_zero");
    go(7);

    // Elapsed saturation with the time limit disabled
    bus_b.start_btn = 1'b1;
    t0 = cyc;
    chk(1, 2, CARV, 1, 0, 0, 2'b00, 0, 0, "b_carve");
    chk(1, 4, PLAY, 0, 1, 0, 2'b00, 0, 0, "b_play");
    chk(1, 6, PLAY, 0, 1, 0, 2'b00, 1, 0, "b_el1");
    chk(1, 8, PLAY, 0, 1, 0, 2'b00, 2, 0, "b_el2");
    chk(1, 10, PLAY, 0, 1, 0, 2'b00, 3, 0, "b_el3");
    chk(1, 16, PLAY, 0, 1, 0, 2'b00, 3, 0, "b_sat");
    chk(1, 30, PLAY, 0, 1, 0, 2'b00, 3, 0, "b_no_to");
    go(30);

    // Reset landing on a carve_start pulse
    place_a(0, 0, 1, 0);
    restart_a();
    chk(0, 2, CARV, 1, 0, 0, 2'b00, 0, 0, "pulse_pre");
    go(2);
    reset = 1'b0;
    chk(0, 3, IDLE, 0, 0, 0, 2'b00, 0, 0, "mid_reset");
    go(3);
    reset = 1'b1;
    go(6);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover: %0d expectations never sampled, want 0",
               sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
